// File: rtl/frac_clk_divider_if.sv
// rtl/frac_clk_divider_if.sv - control/status bundle for the fractional clock divider
interface frac_clk_divider_if #(
  parameter int NCH   = 2,
  parameter int ACC_W = 24
);
  logic                   locked;
  logic [NCH-1:0]         en;
  logic [NCH-1:0]         clr;
  logic [NCH-1:0]         inc_wr;
  logic [ACC_W-1:0]       inc_wdata;
  logic [NCH-1:0]         clk_out;
  logic [NCH-1:0]         tick;
  logic [NCH*ACC_W-1:0]   inc_rdata;

  modport master (
    output locked, en, clr, inc_wr, inc_wdata,
    input  clk_out, tick, inc_rdata
  );

  modport slave (
    input  locked, en, clr, inc_wr, inc_wdata,
    output clk_out, tick, inc_rdata
  );
endinterface

// File: rtl/frac_clk_divider.sv
// rtl/frac_clk_divider.sv - multi-channel phase-accumulator fractional clock divider
module frac_clk_divider #(
  parameter int NCH     = 2,
  parameter int ACC_W   = 24,
  parameter int INC_RST = 68719
) (
  input  logic               clk,
  input  logic               rst_n,
  frac_clk_divider_if.slave  bus
);
  localparam logic [ACC_W-1:0] INC_INIT = ACC_W'(INC_RST);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic             clk_r;
    logic             tick_r;
    logic [ACC_W:0]   sum;

    // Addition always uses the pre-write increment; a same-edge write lands next cycle.
    assign sum = {1'b0, acc} + {1'b0, inc};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc    <= '0;
        inc    <= INC_INIT;
        clk_r  <= 1'b0;
        tick_r <= 1'b0;
      end else begin
        if (bus.inc_wr[g]) begin
          inc <= bus.inc_wdata;
        end
        if (!bus.locked || bus.clr[g]) begin
          acc    <= '0;
          clk_r  <= 1'b0;
          tick_r <= 1'b0;
        end else if (bus.en[g]) begin
          acc    <= sum[ACC_W-1:0];
          tick_r <= sum[ACC_W];
          clk_r  <= clk_r ^ sum[ACC_W];
        end else begin
          tick_r <= 1'b0;
        end
      end
    end

    assign bus.clk_out[g]                  = clk_r;
    assign bus.tick[g]                     = tick_r;
    assign bus.inc_rdata[g*ACC_W +: ACC_W] = inc;
  end
endmodule

// File: tb/tb_frac_clk_divider.sv
// tb/tb_frac_clk_divider.sv - directed bench with a cycle-level behavioural model
module tb_frac_clk_divider;
  localparam int NCH     = 2;
  localparam int ACC_W   = 8;
  localparam int INC_RST = 68719;
  localparam int MOD     = 1 << ACC_W;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  bit   live = 0;

  frac_clk_divider_if #(.NCH(NCH), .ACC_W(ACC_W)) bus ();

  frac_clk_divider #(.NCH(NCH), .ACC_W(ACC_W), .INC_RST(INC_RST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int m_acc [NCH];
  int m_inc [NCH];
  bit m_clk [NCH];
  bit m_tick[NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: accumulator as a plain integer modulo 2^ACC_W, a tick whenever the sum overflows.
  always @(posedge clk or negedge rst_n) begin
    int old_inc;
    int s;
    if (!rst_n) begin
      for (int ch = 0; ch < NCH; ch++) begin
        m_acc[ch] = 0; m_inc[ch] = INC_RST % MOD; m_clk[ch] = 0; m_tick[ch] = 0;
      end
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        old_inc = m_inc[ch];
        if (bus.inc_wr[ch]) m_inc[ch] = int'(bus.inc_wdata);
        if (!bus.locked || bus.clr[ch]) begin
          m_acc[ch] = 0; m_clk[ch] = 0; m_tick[ch] = 0;
        end else if (bus.en[ch]) begin
          s = m_acc[ch] + old_inc;
          m_tick[ch] = (s >= MOD);
          m_acc[ch] = s % MOD;
          m_clk[ch] = m_clk[ch] ^ m_tick[ch];
        end else begin
          m_tick[ch] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      for (int ch = 0; ch < NCH; ch++) begin
        check($sformatf("model_clk_out[%0d]", ch), 32'(bus.clk_out[ch]), 32'(m_clk[ch]));
        check($sformatf("model_tick[%0d]", ch), 32'(bus.tick[ch]), 32'(m_tick[ch]));
        check($sformatf("model_inc_rdata[%0d]", ch), 32'(bus.inc_rdata[ch*ACC_W +: ACC_W]), 32'(m_inc[ch]));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    bus.locked = 1'b0; bus.en = '0; bus.clr = '0; bus.inc_wr = '0; bus.inc_wdata = '0;
    repeat (3) step();
    check("reset_clk_out", 32'(bus.clk_out), 32'h0);
    check("reset_tick", 32'(bus.tick), 32'h0);
    check("reset_inc_rdata", 32'(bus.inc_rdata), 32'h6F6F);
    rst_n = 1'b1;
    live = 1;

    // Ch0 inc=64 from acc=0; ch1 runs on its reset increment throughout.
    bus.locked = 1'b1; bus.inc_wr = 2'b01; bus.inc_wdata = 8'd64; bus.en = 2'b10;
    step();
    bus.inc_wr = '0; bus.en = 2'b11;
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("inc64_tick_k%0d", k), 32'(bus.tick[0]), 32'((k % 4) == 0));
      check($sformatf("inc64_clk_k%0d", k), 32'(bus.clk_out[0]), 32'((k / 4) % 2));
    end
    repeat (2) step();

    // acc=0x80: freeze for 10 cycles, then two enabled edges to the carry.
    bus.en = 2'b10;
    for (int k = 0; k < 10; k++) begin
      step();
      check("freeze_tick", 32'(bus.tick[0]), 32'h0);
      check("freeze_clk", 32'(bus.clk_out[0]), 32'h0);
    end
    bus.en = 2'b11;
    step();
    check("resume_tick1", 32'(bus.tick[0]), 32'h0);
    step();
    check("resume_tick2", 32'(bus.tick[0]), 32'h1);
    check("resume_clk2", 32'(bus.clk_out[0]), 32'h1);

    // Clear ch0 while its clk_out is high.
    bus.clr = 2'b01;
    step();
    check("clr_clk", 32'(bus.clk_out[0]), 32'h0);
    check("clr_tick", 32'(bus.tick[0]), 32'h0);
    bus.clr = '0;
    repeat (3) step();
    check("post_clr_no_tick", 32'(bus.tick[0]), 32'h0);

    // Write 255 on the carry edge: the carry still comes from inc=64.
    bus.inc_wr = 2'b01; bus.inc_wdata = 8'd255;
    step();
    bus.inc_wr = '0;
    check("wr_edge_tick", 32'(bus.tick[0]), 32'h1);
    check("wr_edge_clk", 32'(bus.clk_out[0]), 32'h1);
    check("wr_rdata", 32'(bus.inc_rdata[7:0]), 32'hFF);
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      cnt += int'(bus.tick[0]);
    end
    check("inc255_ticks", 32'(cnt), 32'd255);

    // inc=3 for exactly 256 enabled cycles from a clean start.
    bus.clr = 2'b01; bus.inc_wr = 2'b01; bus.inc_wdata = 8'd3;
    step();
    bus.clr = '0; bus.inc_wr = '0;
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      cnt += int'(bus.tick[0]);
    end
    check("inc3_ticks", 32'(cnt), 32'd3);
    check("inc3_clk", 32'(bus.clk_out[0]), 32'h1);

    // Lock loss clears every channel; the increment write made meanwhile survives.
    bus.locked = 1'b0; bus.inc_wr = 2'b01; bus.inc_wdata = 8'd64;
    step();
    check("unlock_clk", 32'(bus.clk_out), 32'h0);
    check("unlock_rdata", 32'(bus.inc_rdata[7:0]), 32'h40);
    bus.locked = 1'b1; bus.inc_wr = '0;
    repeat (4) step();
    check("relock_clk", 32'(bus.clk_out[0]), 32'h1);

    // Asynchronous reset mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    check("async_clk", 32'(bus.clk_out), 32'h0);
    check("async_tick", 32'(bus.tick), 32'h0);
    check("async_rdata", 32'(bus.inc_rdata), 32'h6F6F);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frac_clk_divider.md
Name: frac_clk_divider

Overview:
- Multi-channel fractional clock divider. Generalised successor of the fixed 8.388 MHz -> 32.768 kHz divider in the FPGA top level.
- Derives low-rate clocks (e.g. the 32.768 kHz AON lfextclk) and periodic tick strobes from a single fabric clock (16 MHz hfextclk). No dedicated MMCM output is needed per rate.
- Each channel is a phase accumulator with a runtime-programmable increment, enable, synchronous clear and MMCM-lock gating.
- Sits in the top level between the MMCM/reset block and the SoC.

Parameters:
- NCH, 2, number of independent divider channels (1..8).
- ACC_W, 24, accumulator width in bits (8..32).
- INC_RST, 68719, reset value of every channel's increment shadow. This is 32.768 kHz x 2 x 2^24 / 16 MHz, rounded down.

Ports:
- clk  input  1  fabric clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- locked  input  1  MMCM lock. Low acts as clear on all channels.
- en  input  NCH  per-channel count enable.
- clr  input  NCH  per-channel synchronous clear.
- inc_wr  input  NCH  per-channel increment write strobe.
- inc_wdata  input  ACC_W  increment value, written to every channel whose inc_wr bit is 1.
- clk_out  output  NCH  divided clock per channel, registered, 50% average duty.
- tick  output  NCH  one-cycle strobe per channel at each clk_out toggle.
- inc_rdata  output  NCH*ACC_W  current increment per channel, packed; channel i in [i*ACC_W +: ACC_W].

Behaviour:
- Reset (rst_n low, asynchronous):
  - acc[i] = 0, clk_out = 0, tick = 0.
  - inc[i] = INC_RST[ACC_W-1:0].
  - Release is synchronous to the next clk edge.
- Per channel i, per rising edge, in priority order:
  1. If locked==0 or clr[i]==1: acc<=0, clk_out[i]<=0, tick[i]<=0.
  2. Else if en[i]==1: {carry,sum} = acc + inc (ACC_W+1 bits). acc<=sum (wraps mod 2^ACC_W), tick[i]<=carry, clk_out[i]<=clk_out[i]^carry.
  3. Else (disabled): acc and clk_out[i] hold; tick[i]<=0.
- Latency: tick and clk_out change in the same cycle, one cycle after the edge that produced the carry. Outputs are pure flops, with no combinational path from any input.
- Increment write:
  - inc_wr[i] at edge k loads inc[i]<=inc_wdata.
  - The new value is first used by the addition at edge k+1. The addition at edge k uses the old value.
  - inc_wr is independent of en, clr and locked. Writes during clear or disable are kept.
  - inc_rdata reflects the write from edge k+1 onward.
- Rate:
  - Average tick rate is f_clk * inc / 2^ACC_W; clk_out frequency is half of that.
  - Edge jitter is at most 1 clk period.
  - inc=0: no ticks; clk_out holds.
  - inc=2^ACC_W-1: carry on every enabled edge except one per 2^ACC_W edges.
- Channels are fully independent; simultaneous events on different channels do not interact.
- clk_out is fabric logic, not a global clock. The SoC lfextclk consumer must treat it as a low-rate clock (BUFG insertion is the top level's concern).

Test Plan:
- ACC_W=8, inc=64, en=1, locked=1, from reset -> tick on cycles 4,8,12,... after enable; clk_out period 8 cycles, high 4 / low 4.
- ACC_W=8, inc=3, en=1 for exactly 256 cycles -> exactly 3 ticks; acc returns to 0; clk_out = 1.
- Mid-run (acc=0x80, inc=64): drop en for 10 cycles -> tick=0 and acc, clk_out frozen; re-raise -> next tick after exactly 2 more enabled cycles.
- Assert clr[0] one cycle while clk_out[0]=1 -> next cycle clk_out[0]=0, acc=0. Channel 1 unaffected (compare against its running model).
- Write inc=255 via inc_wr on the same cycle a carry occurs -> that carry uses the old inc; from the next edge ticks occur on 255 of 256 cycles; inc_rdata = 0xFF.
- Drop locked, then assert rst_n=0 mid-count -> all clk_out and tick 0 immediately; after reset inc_rdata = INC_RST per channel; 32768 Hz check with defaults over 16e6 cycles -> 65536 +/- 1 ticks (long regression only).
